// File: rtl/hsem_ahb_pkg.sv
// hsem_ahb_pkg: AHB encodings and FSM states shared by the
// hardware-semaphore AHB slave and its byte-strobe generator.
package hsem_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } hsem_state_e;

endpackage

// File: rtl/hsem_ahb_slv_if.sv
// hsem_ahb_slv_if: AHB slave port plus regfile access port of the
// hardware-semaphore bus interface, seen from slave or environment.
interface hsem_ahb_slv_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    import hsem_ahb_pkg::*;

    logic                  hsel;
    logic                  hready;
    logic [1:0]            htrans;
    logic [2:0]            hsize;
    logic                  hwrite;
    logic [31:0]           haddr;
    logic [DATA_W-1:0]     hwdata;
    logic                  hreadyout;
    logic [1:0]            hresp;
    logic [DATA_W-1:0]     hrdata;
    logic [ADDR_W-1:0]     reg_addr;
    logic [DATA_W/8-1:0]   reg_be;
    logic                  reg_wr;
    logic                  reg_rd;
    logic [DATA_W-1:0]     reg_wdata;
    logic [DATA_W-1:0]     reg_rdata;
    logic                  reg_ack;

    modport slave (
        input  hsel, hready, htrans, hsize, hwrite, haddr, hwdata,
        input  reg_rdata, reg_ack,
        output hreadyout, hresp, hrdata,
        output reg_addr, reg_be, reg_wr, reg_rd, reg_wdata
    );

    modport master (
        output hsel, hready, htrans, hsize, hwrite, haddr, hwdata,
        output reg_rdata, reg_ack,
        input  hreadyout, hresp, hrdata,
        input  reg_addr, reg_be, reg_wr, reg_rd, reg_wdata
    );

endinterface

// File: rtl/hsem_ahb_strb_gen.sv
// hsem_ahb_strb_gen: hsize/haddr to byte enables, flagging transfers
// that are wider than the bus or misaligned to their own size.
module hsem_ahb_strb_gen
    import hsem_ahb_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int BB     = $clog2(NB)
) (
    input  logic [2:0]    i_hsize,
    input  logic [BB-1:0] i_off,
    output logic [NB-1:0] o_be,
    output logic          o_bad
);

    int w_len;
    int w_off;

    always_comb begin
        w_len = 1 << i_hsize;
        w_off = int'(i_off);
        o_be  = '0;
        o_bad = (int'(i_hsize) > BB) || ((w_off % w_len) != 0);
        if (!o_bad) begin
            for (int i = 0; i < NB; i++) begin
                o_be[i] = (i >= w_off) && (i < w_off + w_len);
            end
        end
    end

endmodule

// File: rtl/hsem_ahb_slv.sv
// hsem_ahb_slv: AHB slave front end of the semaphore regfile.
// Define HSEM_ERR_RESP_EN to answer illegal/timed-out accesses with ERROR.
module hsem_ahb_slv
    import hsem_ahb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6,
    parameter int NUM_REGS = 32,
    parameter int TIMEOUT  = 16
) (
    input logic           hclk,
    input logic           hreset,
    hsem_ahb_slv_if.slave bus
);

    localparam int NB = DATA_W / 8;
    localparam int BB = $clog2(NB);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    hsem_state_e       r_state;
    logic              r_wr;
    logic              r_rd;
    logic [ADDR_W-1:0] r_addr;
    logic [NB-1:0]     r_be;
    logic [CW-1:0]     r_cnt;

    logic [ADDR_W-1:0] w_idx;
    logic [NB-1:0]     w_be;
    logic              w_bad;
    logic              w_legal;
    logic              w_acc;
    logic              w_busy;
    logic              w_act;
    logic              w_done;
    logic              w_tout;
    logic              w_open;
    logic              w_take;
    logic              w_rdy;
    logic              w_unused;

    assign w_idx = bus.haddr[ADDR_W+BB-1:BB];
    assign w_unused = ^bus.haddr[31:ADDR_W+BB];

    hsem_ahb_strb_gen #(.DATA_W(DATA_W)) u_strb (
        .i_hsize (bus.hsize),
        .i_off   (bus.haddr[BB-1:0]),
        .o_be    (w_be),
        .o_bad   (w_bad)
    );

    assign w_legal = ~w_bad
                   & ({1'b0, w_idx} < (ADDR_W + 1)'(NUM_REGS));
    assign w_acc   = bus.hsel & bus.hready
                   & (bus.htrans == HTRANS_NONSEQ
                   || bus.htrans == HTRANS_SEQ);

    // A data phase with no strobe (dropped access) completes at once
    assign w_busy = (r_state == ST_ACCESS) || (r_state == ST_WAIT);
    assign w_act  = r_wr | r_rd;
    assign w_done = w_busy & (~w_act | bus.reg_ack);
    assign w_tout = (r_state == ST_WAIT) & w_act & ~bus.reg_ack
                  & (r_cnt == CNT_MAX);

    always_comb begin
        w_rdy  = 1'b1;
        w_open = 1'b0;
        unique case (1'b1)
            w_busy: begin
                w_rdy  = w_done;
                w_open = w_done;
            end
            (r_state == ST_IDLE): w_open = 1'b1;
`ifdef HSEM_ERR_RESP_EN
            (r_state == ST_ERR1): w_rdy  = 1'b0;
            (r_state == ST_ERR2): w_open = 1'b1;
`endif
            default: ;
        endcase
    end

    assign w_take = w_acc & w_open;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state <= ST_IDLE;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_cnt   <= '0;
        end else if (w_take) begin
            r_addr <= w_idx;
            r_be   <= w_be;
            r_cnt  <= '0;
            r_wr   <= w_legal & bus.hwrite;
            r_rd   <= w_legal & ~bus.hwrite;
`ifdef HSEM_ERR_RESP_EN
            r_state <= w_legal ? ST_ACCESS : ST_ERR1;
`else
            r_state <= ST_ACCESS;
`endif
        end else if (w_tout) begin
            // Without ERROR support, stay in WAIT strobe-less for an OKAY finish
            r_wr <= 1'b0;
            r_rd <= 1'b0;
`ifdef HSEM_ERR_RESP_EN
            r_state <= ST_ERR1;
`endif
        end else if (w_done) begin
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_state <= ST_IDLE;
        end else if (w_busy) begin
            r_state <= ST_WAIT;
            if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
`ifdef HSEM_ERR_RESP_EN
        end else if (r_state == ST_ERR1) begin
            r_state <= ST_ERR2;
        end else if (r_state == ST_ERR2) begin
            r_state <= ST_IDLE;
`endif
        end
    end

    assign bus.hreadyout = w_rdy;
`ifdef HSEM_ERR_RESP_EN
    assign bus.hresp = (r_state == ST_ERR1 || r_state == ST_ERR2)
                     ? HRESP_ERROR : HRESP_OKAY;
`else
    assign bus.hresp = HRESP_OKAY;
`endif
    assign bus.hrdata    = (r_rd & bus.reg_ack) ? bus.reg_rdata : '0;
    assign bus.reg_addr  = r_addr;
    assign bus.reg_be    = r_be;
    assign bus.reg_wr    = r_wr;
    assign bus.reg_rd    = r_rd;
    assign bus.reg_wdata = bus.hwdata;

endmodule

// File: tb/tb_hsem_ahb_slv.sv
// tb_hsem_ahb_slv: directed and random transfers against a
// per-cycle expectation list built from the bus protocol rules.
module tb_hsem_ahb_slv;
    import hsem_ahb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NR = 32;
    localparam int TO = 4;

    typedef struct {
        bit          rdy;
        bit [1:0]    resp;
        bit          wr;
        bit          rd;
        logic [31:0] rdata;
    } cyc_t;

    logic hclk = 1'b0;
    logic hreset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    hsem_ahb_slv_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    hsem_ahb_slv #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_REGS (NR),
        .TIMEOUT  (TO)
    ) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    always #5 hclk = ~hclk;

    assign bus.hready = bus.hreadyout;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic idle_bus();
        bus.hsel   = 1'b0;
        bus.htrans = HTRANS_IDLE;
    endtask

    task automatic addr_phase(input bit wr, input logic [31:0] a,
                              input int sz);
        bus.hsel   = 1'b1;
        bus.htrans = HTRANS_NONSEQ;
        bus.hwrite = wr;
        bus.haddr  = a;
        bus.hsize  = 3'(sz);
    endtask

    function automatic bit m_legal(input logic [31:0] a, input int sz);
        int idx;
        idx = int'((a / 4) % (1 << AW));
        return (sz <= 2) && ((a % (1 << sz)) == 0) && (idx < NR);
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] a,
                                        input int sz);
        logic [31:0] m;
        m = (32'd1 << (1 << sz)) - 1;
        return 4'(m << (a % 4));
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"}, bus.hreadyout, 1'b1);
        chk({tag, "_resp"}, bus.hresp, HRESP_OKAY);
        chk({tag, "_rdata"}, bus.hrdata, 32'h0);
        chk({tag, "_wr"}, bus.reg_wr, 1'b0);
        chk({tag, "_rd"}, bus.reg_rd, 1'b0);
        chk({tag, "_addr"}, bus.reg_addr, 6'h0);
        chk({tag, "_be"}, bus.reg_be, 4'h0);
    endtask

    // Entered mid-cycle with the slave idle; leaves it idle again
    task automatic xfer(input bit wr, input logic [31:0] a, input int sz,
                        input logic [31:0] wd, input int dly,
                        input logic [31:0] rv);
        cyc_t q[$];
        bit ok;
        logic [5:0] idx;
        logic [3:0] be;
        ok  = m_legal(a, sz);
        idx = a[7:2];
        be  = m_be(a, sz);
        if (!ok) begin
`ifdef HSEM_ERR_RESP_EN
            q.push_back('{1'b0, 2'b01, 1'b0, 1'b0, 32'h0});
            q.push_back('{1'b1, 2'b01, 1'b0, 1'b0, 32'h0});
`else
            q.push_back('{1'b1, 2'b00, 1'b0, 1'b0, 32'h0});
`endif
        end else begin
            for (int i = 0; i < dly && i <= TO; i++)
                q.push_back('{1'b0, 2'b00, wr, !wr, 32'h0});
            if (dly <= TO) begin
                q.push_back('{1'b1, 2'b00, wr, !wr, wr ? 32'h0 : rv});
            end else begin
`ifdef HSEM_ERR_RESP_EN
                q.push_back('{1'b0, 2'b01, 1'b0, 1'b0, 32'h0});
                q.push_back('{1'b1, 2'b01, 1'b0, 1'b0, 32'h0});
`else
                q.push_back('{1'b1, 2'b00, 1'b0, 1'b0, 32'h0});
`endif
            end
        end
        addr_phase(wr, a, sz);
        bus.reg_ack = 1'b0;
        tick();
        idle_bus();
        bus.hwdata    = wd;
        bus.reg_rdata = rv;
        for (int i = 0; i < q.size(); i++) begin
            if (i > 0) tick();
            bus.reg_ack = ok && (i == dly);
            #1;
            chk("hreadyout", bus.hreadyout, q[i].rdy);
            chk("hresp", bus.hresp, q[i].resp);
            chk("hrdata", bus.hrdata, q[i].rdata);
            chk("reg_wr", bus.reg_wr, q[i].wr);
            chk("reg_rd", bus.reg_rd, q[i].rd);
            if (q[i].wr || q[i].rd) begin
                chk("reg_addr", bus.reg_addr, idx);
                chk("reg_be", bus.reg_be, be);
                if (q[i].wr) chk("reg_wdata", bus.reg_wdata, wd);
            end
        end
        tick();
        bus.reg_ack = 1'b0;
        #1;
        chk("post_wr", bus.reg_wr, 1'b0);
        chk("post_rd", bus.reg_rd, 1'b0);
    endtask

    bit          r_wr;
    int          r_sz;
    int          r_dly;
    logic [31:0] r_a;

    initial begin
        idle_bus();
        bus.hwrite    = 1'b0;
        bus.haddr     = 32'h0;
        bus.hsize     = 3'd0;
        bus.hwdata    = 32'h0;
        bus.reg_rdata = 32'h0;
        bus.reg_ack   = 1'b0;
        repeat (2) tick();
        addr_phase(1'b1, 32'h4, 2);
        tick();
        hreset = 1'b0;
        idle_bus();
        #1;
        chk_reset_vals("rst");
        tick();
        chk("rst_next_wr", bus.reg_wr, 1'b0);

        xfer(1'b1, 32'h08, 2, 32'hDEADBEEF, 0, 32'h0);
        xfer(1'b1, 32'h0D, 0, 32'h11223344, 0, 32'h0);
        xfer(1'b1, 32'h0E, 1, 32'h55667788, 1, 32'h0);
        xfer(1'b0, 32'h04, 2, 32'h0, 2, 32'h1234);
        xfer(1'b0, 32'h80, 2, 32'h0, 0, 32'hCAFEF00D);
        xfer(1'b0, 32'h01, 1, 32'h0, 0, 32'hCAFEF00D);
        xfer(1'b1, 32'h00, 3, 32'h12345678, 0, 32'h0);
        xfer(1'b0, 32'h10, 2, 32'h0, 99, 32'hBEEF);
        xfer(1'b0, 32'h7C, 2, 32'h0, TO, 32'h600D);

        for (int k = 0; k < 30; k++) begin
            r_wr  = 1'($urandom_range(0, 1));
            r_sz  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            r_a   = $urandom_range(0, 32'h9F);
            if ($urandom_range(0, 3) != 0)
                r_a = r_a & ~((32'd1 << r_sz) - 1);
            r_dly = ($urandom_range(0, 7) == 0) ? 99 : $urandom_range(0, 3);
            xfer(r_wr, r_a, r_sz, $urandom, r_dly, $urandom);
        end

        addr_phase(1'b0, 32'h4, 2);
        bus.reg_ack   = 1'b0;
        bus.reg_rdata = 32'h55;
        tick();
        idle_bus();
        tick();
        chk("wait_rdy", bus.hreadyout, 1'b0);
        chk("wait_rd", bus.reg_rd, 1'b1);
        hreset = 1'b1;
        tick();
        hreset = 1'b0;
        #1;
        chk_reset_vals("midrst");

        tick();
        addr_phase(1'b1, 32'h0C, 2);
        bus.reg_ack = 1'b1;
        tick();
        addr_phase(1'b1, 32'h10, 2);
        bus.hwdata = 32'hA5A50001;
        #1;
        chk("b2b1_wr", bus.reg_wr, 1'b1);
        chk("b2b1_addr", bus.reg_addr, 6'd3);
        chk("b2b1_rdy", bus.hreadyout, 1'b1);
        chk("b2b1_wdata", bus.reg_wdata, 32'hA5A50001);
        tick();
        idle_bus();
        bus.hwdata = 32'h5A5A0002;
        #1;
        chk("b2b2_wr", bus.reg_wr, 1'b1);
        chk("b2b2_addr", bus.reg_addr, 6'd4);
        chk("b2b2_rdy", bus.hreadyout, 1'b1);
        chk("b2b2_wdata", bus.reg_wdata, 32'h5A5A0002);
        tick();
        bus.reg_ack = 1'b0;
        #1;
        chk("b2b_end_wr", bus.reg_wr, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
